// File: rtl/alu_seq.sv
// rtl/alu_seq.sv - multi-cycle MULU/DIVU/SHL/SHR sequencer steering an external 16-bit alu
// Alu drive outputs are decoded from registered state only; rshf/cf return within the same cycle.
module alu_seq #(
  parameter int          W      = 16,
  parameter logic [15:0] DIV0_Q = 16'hFFFF
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [1:0]   cmd,
  input  logic [W-1:0] opa,
  input  logic [W-1:0] opb,
  output logic         busy,
  output logic         done,
  output logic         err,
  output logic [W-1:0] res_hi,
  output logic [W-1:0] res_lo,
  output logic [3:0]   op_alu,
  output logic [3:0]   op_shf,
  output logic [W-1:0] alu_t,
  output logic [W-1:0] alu_y,
  output logic         alu_c,
  output logic         alu_n15,
  output logic         alu_n0,
  input  logic [W:0]   rshf,
  input  logic         cf
);

  typedef enum logic [2:0] {
    S_IDLE, S_MUL, S_DIV_SH, S_DIV_SUB, S_SHF, S_DONE
  } state_t;

  state_t         state_q, state_d;
  logic [W-1:0]   p_q, p_d, q_q, q_d, m_q, m_d;
  logic [W-1:0]   res_hi_q, res_hi_d, res_lo_q, res_lo_d;
  logic [4:0]     cnt_q, cnt_d;
  logic           r16_q, r16_d, shr_q, shr_d, err_q, err_d;
  logic           qbit;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      p_q      <= '0;
      q_q      <= '0;
      m_q      <= '0;
      res_hi_q <= '0;
      res_lo_q <= '0;
      cnt_q    <= '0;
      r16_q    <= 1'b0;
      shr_q    <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      p_q      <= p_d;
      q_q      <= q_d;
      m_q      <= m_d;
      res_hi_q <= res_hi_d;
      res_lo_q <= res_lo_d;
      cnt_q    <= cnt_d;
      r16_q    <= r16_d;
      shr_q    <= shr_d;
      err_q    <= err_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    p_d      = p_q;
    q_d      = q_q;
    m_d      = m_q;
    res_hi_d = res_hi_q;
    res_lo_d = res_lo_q;
    cnt_d    = cnt_q;
    r16_d    = r16_q;
    shr_d    = shr_q;
    err_d    = err_q;
    qbit     = 1'b0;
    op_alu   = 4'b0000;
    op_shf   = 4'b0000;
    alu_t    = '0;
    alu_y    = '0;
    alu_c    = 1'b0;

    case (state_q)
      S_IDLE, S_DONE: begin
        state_d = S_IDLE;
        if (start) begin
          err_d = 1'b0;
          case (cmd)
            2'b00: begin
              p_d     = '0;
              q_d     = opa;
              m_d     = opb;
              cnt_d   = 5'(W - 1);
              state_d = S_MUL;
            end
            2'b01: begin
              if (opb == '0) begin
                err_d    = 1'b1;
                res_lo_d = DIV0_Q;
                res_hi_d = opa;
                state_d  = S_DONE;
              end else begin
                p_d     = '0;
                q_d     = opa;
                m_d     = opb;
                cnt_d   = 5'(W - 1);
                state_d = S_DIV_SH;
              end
            end
            default: begin
              q_d   = opa;
              cnt_d = {1'b0, opb[3:0]};
              shr_d = cmd[0];
              if (opb[3:0] == 4'd0) begin
                res_lo_d = opa;
                res_hi_d = '0;
                state_d  = S_DONE;
              end else begin
                state_d = S_SHF;
              end
            end
          endcase
        end
      end

      // Shift-add step: the alu adds and rotates the 17-bit sum right by one.
      S_MUL: begin
        op_alu = 4'b1000;
        op_shf = 4'b0101;
        alu_t  = p_q;
        alu_y  = q_q[0] ? m_q : '0;
        p_d    = rshf[W-1:0];
        q_d    = {rshf[W], q_q[W-1:1]};
        if (cnt_q == 5'd0) begin
          res_hi_d = p_d;
          res_lo_d = q_d;
          state_d  = S_DONE;
        end else begin
          cnt_d = cnt_q - 5'd1;
        end
      end

      S_DIV_SH: begin
        op_shf  = 4'b0011;
        alu_t   = p_q;
        alu_c   = q_q[W-1];
        r16_d   = rshf[W];
        p_d     = rshf[W-1:0];
        q_d     = {q_q[W-2:0], 1'b0};
        state_d = S_DIV_SUB;
      end

      // A bit shifted out of P means the partial remainder already exceeds M.
      S_DIV_SUB: begin
        op_alu = 4'b0100;
        alu_t  = p_q;
        alu_y  = m_q;
        qbit   = cf | r16_q;
        if (qbit) p_d = rshf[W-1:0];
        q_d = {q_q[W-1:1], qbit};
        if (cnt_q == 5'd0) begin
          res_lo_d = q_d;
          res_hi_d = p_d;
          state_d  = S_DONE;
        end else begin
          cnt_d   = cnt_q - 5'd1;
          state_d = S_DIV_SH;
        end
      end

      S_SHF: begin
        op_shf = shr_q ? 4'b0110 : 4'b0010;
        alu_t  = q_q;
        q_d    = rshf[W-1:0];
        if (cnt_q == 5'd1) begin
          res_lo_d = rshf[W-1:0];
          res_hi_d = '0;
          state_d  = S_DONE;
        end else begin
          cnt_d = cnt_q - 5'd1;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  assign busy    = (state_q == S_MUL) || (state_q == S_DIV_SH) ||
                   (state_q == S_DIV_SUB) || (state_q == S_SHF);
  assign done    = (state_q == S_DONE);
  assign err     = err_q;
  assign res_hi  = res_hi_q;
  assign res_lo  = res_lo_q;
  assign alu_n15 = 1'b0;
  assign alu_n0  = 1'b0;

endmodule
